// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH slots of {valid, ctrl, data}
// with stall hold, flush bubble insertion and saturating stall/flush counters.
module pipe_stage_reg #(
  parameter int CTRL_W            = 16,
  parameter int DATA_W            = 320,
  parameter int DEPTH             = 1,
  parameter bit CLR_DATA_ON_FLUSH = 1'b0,
  parameter int CNT_W             = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
    $error("pipe_stage_reg: DEPTH must be in 1..4");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;

  // Bubbles entering slot 0 carry zero control so a dead entry can never write state downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= '0;
      ctrl_q  <= '0;
      if (CLR_DATA_ON_FLUSH) begin
        data_q <= '0;
      end
    end else if (!stall) begin
      valid_q[0] <= valid_in;
      ctrl_q[0]  <= valid_in ? ctrl_in : '0;
      data_q[0]  <= data_in;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        ctrl_q[k]  <= ctrl_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

  // A flush only counts when it actually killed something; flush hides a coincident stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (flush) begin
      if ((|valid_q) && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end else if (stall) begin
      if (stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
    end
  end

  assign valid_out = valid_q[DEPTH-1];
  assign ctrl_out  = ctrl_q[DEPTH-1];
  assign data_out  = data_q[DEPTH-1];

endmodule
